img_diff_binarizer: RTL and testbench
=====================================

# img_diff_binarizer

Streaming stage that consumes the saturated absolute-difference pixel stream produced by the frame subtractor. Each pixel is compared against a per-frame threshold and emitted as a 1-bit foreground mask. The stage also accumulates per-frame motion statistics: foreground pixel count and foreground bounding box. A one-cycle report pulse is issued at end of frame for the downstream motion-detect controller.

## Interface
- WIDTH, 8, pixel data width
- X_W, 11, column counter / bbox x width
- Y_W, 11, row counter / bbox y width
- CNT_W, 22, foreground count width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- diff_valid  in  1  input pixel qualifier
- diff_sof  in  1  first pixel of frame, qualified by diff_valid
- diff_eol  in  1  last pixel of line, qualified by diff_valid
- diff_eof  in  1  last pixel of frame, qualified by diff_valid
- diff_data  in  WIDTH  difference pixel, unsigned
- thresh  in  WIDTH  foreground threshold, sampled on sof pixel
- bin_valid  out  1  mask pixel qualifier
- bin_sof / bin_eol / bin_eof  out  1  delayed frame markers
- bin_data  out  1  1 = foreground
- stats_valid  out  1  one-cycle end-of-frame report strobe
- fg_count  out  CNT_W  foreground pixels in the reported frame
- bbox_xmin / bbox_xmax  out  X_W  bbox columns, inclusive
- bbox_ymin / bbox_ymax  out  Y_W  bbox rows, inclusive
- bbox_empty  out  1  reported frame had no foreground
- frame_abort  out  1  one-cycle pulse: frame truncated by early sof

## Operation
- States: IDLE (no frame open) and ACTIVE (frame open).
- IDLE: valid pixels without diff_sof are dropped. No bin_valid is produced and no statistics are updated.
- A valid pixel with diff_sof, in either state, opens a frame:
  - thr_q <= thresh.
  - x = 0, y = 0.
  - count and bbox accumulators are cleared before this pixel is accumulated.
  - Next state is ACTIVE.
- Foreground test: diff_data > thr_q, strictly greater. The sof pixel is tested against the newly sampled thresh.
- Per accepted pixel:
  - x increments.
  - On diff_eol, x <= 0 and y increments.
  - x and y saturate at all-ones and do not wrap.
- Per foreground pixel:
  - count increments, saturating at 2^CNT_W-1.
  - xmin/xmax/ymin/ymax are updated with min/max against the current x,y.
  - The first foreground pixel of a frame loads all four bbox values directly.
- diff_eof on an accepted pixel closes the frame, including that pixel. On the next cycle stats_valid = 1 and all stats outputs are loaded. Next state is IDLE.
- sof and eof on the same pixel form a valid one-pixel frame: report count 0/1 and bbox (0,0,0,0) when that pixel is foreground.
- sof arriving in ACTIVE without a preceding eof:
  - frame_abort pulses.
  - No stats_valid is issued for the old frame.
  - The new frame opens normally on that pixel.
- Stats outputs hold their last reported values until the next stats_valid.
- When bbox_empty = 1, all bbox outputs are 0 and fg_count = 0.
- diff_sof/eol/eof with diff_valid = 0 are ignored.

## Timing
- Mask latency is 1 cycle: a pixel accepted at cycle N gives bin_valid/bin_data/markers registered at N+1.
- No backpressure. One pixel per cycle is sustained, including back-to-back frames: an eof at N and sof at N+1 are both accepted.
- stats_valid is asserted at N+1 for an eof pixel at N, coincident with bin_eof.
- frame_abort is asserted at N+1 for an early sof at N, coincident with bin_sof.
- Reset, asserted at any time and taking effect immediately:
  - State returns to IDLE.
  - All outputs go to 0, except bbox_empty = 1.
  - thr_q, counters and accumulators go to 0.
  - A frame in progress is discarded without report or abort pulse.
- After reset release, the first accepted pixel must carry diff_sof.

## Test plan
- 4x3 frame, thresh=10, all pixels 10 except (x=1,y=0)=11 and (x=3,y=2)=200 -> bin_data 1 only at those two pixels, 1 cycle late; stats_valid after eof with fg_count=2, bbox (1,0)-(3,2), bbox_empty=0.
- Same frame, all pixels ≤ thresh -> fg_count=0, bbox_empty=1, bbox all 0.
- thresh changes mid-frame from 10 to 0 -> next frame's classification unaffected until its sof; next frame uses 0.
- sof at row 1 of an open frame -> frame_abort pulse, no stats_valid, new frame reports only its own pixels.
- Single pixel with sof=eof=1, data=255, thresh=0 -> stats_valid next cycle, fg_count=1, bbox (0,0)-(0,0); back-to-back sof next cycle accepted.
- rst_n low mid-frame -> outputs 0 and bbox_empty=1 immediately; pixels without sof after release are dropped.

Source files
------------

// File: rtl/img_diff_binarizer.sv
// Binarizes a saturated absolute-difference pixel stream against a per-frame
// threshold and reports per-frame foreground count and bounding box.
module img_diff_binarizer #(
  parameter int WIDTH = 8,
  parameter int X_W   = 11,
  parameter int Y_W   = 11,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_diff_valid,
  input  logic             i_diff_sof,
  input  logic             i_diff_eol,
  input  logic             i_diff_eof,
  input  logic [WIDTH-1:0] i_diff_data,
  input  logic [WIDTH-1:0] i_thresh,
  output logic             o_bin_valid,
  output logic             o_bin_sof,
  output logic             o_bin_eol,
  output logic             o_bin_eof,
  output logic             o_bin_data,
  output logic             o_stats_valid,
  output logic [CNT_W-1:0] o_fg_count,
  output logic [X_W-1:0]   o_bbox_xmin,
  output logic [X_W-1:0]   o_bbox_xmax,
  output logic [Y_W-1:0]   o_bbox_ymin,
  output logic [Y_W-1:0]   o_bbox_ymax,
  output logic             o_bbox_empty,
  output logic             o_frame_abort
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_thr;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_any;
  logic [X_W-1:0]   r_xmin, r_xmax;
  logic [Y_W-1:0]   r_ymin, r_ymax;

  logic             w_accept, w_fg, w_abort;
  logic [WIDTH-1:0] w_thr;
  logic [X_W-1:0]   w_x_cur, w_x_n, w_xmin_b, w_xmax_b, w_xmin_n, w_xmax_n;
  logic [Y_W-1:0]   w_y_cur, w_y_n, w_ymin_b, w_ymax_b, w_ymin_n, w_ymax_n;
  logic [CNT_W-1:0] w_cnt_b, w_cnt_n;
  logic             w_any_b, w_any_n;

  // A sof pixel sees freshly cleared accumulators and the newly sampled threshold.
  always_comb begin
    w_accept = i_diff_valid && (i_diff_sof || (r_state == ST_ACTIVE));
    w_abort  = w_accept && i_diff_sof && (r_state == ST_ACTIVE);
    w_thr    = i_diff_sof ? i_thresh : r_thr;
    w_fg     = w_accept && (i_diff_data > w_thr);

    if (i_diff_sof) begin
      w_x_cur  = {X_W{1'b0}};
      w_y_cur  = {Y_W{1'b0}};
      w_cnt_b  = {CNT_W{1'b0}};
      w_any_b  = 1'b0;
      w_xmin_b = {X_W{1'b0}};
      w_xmax_b = {X_W{1'b0}};
      w_ymin_b = {Y_W{1'b0}};
      w_ymax_b = {Y_W{1'b0}};
    end else begin
      w_x_cur  = r_x;
      w_y_cur  = r_y;
      w_cnt_b  = r_cnt;
      w_any_b  = r_any;
      w_xmin_b = r_xmin;
      w_xmax_b = r_xmax;
      w_ymin_b = r_ymin;
      w_ymax_b = r_ymax;
    end

    if (i_diff_eol) begin
      w_x_n = {X_W{1'b0}};
      w_y_n = (w_y_cur == {Y_W{1'b1}}) ? w_y_cur : w_y_cur + Y_W'(1);
    end else begin
      w_x_n = (w_x_cur == {X_W{1'b1}}) ? w_x_cur : w_x_cur + X_W'(1);
      w_y_n = w_y_cur;
    end

    if (w_fg) begin
      w_cnt_n = (w_cnt_b == {CNT_W{1'b1}}) ? w_cnt_b : w_cnt_b + CNT_W'(1);
      w_any_n = 1'b1;
      if (!w_any_b) begin
        w_xmin_n = w_x_cur;
        w_xmax_n = w_x_cur;
        w_ymin_n = w_y_cur;
        w_ymax_n = w_y_cur;
      end else begin
        w_xmin_n = (w_x_cur < w_xmin_b) ? w_x_cur : w_xmin_b;
        w_xmax_n = (w_x_cur > w_xmax_b) ? w_x_cur : w_xmax_b;
        w_ymin_n = (w_y_cur < w_ymin_b) ? w_y_cur : w_ymin_b;
        w_ymax_n = (w_y_cur > w_ymax_b) ? w_y_cur : w_ymax_b;
      end
    end else begin
      w_cnt_n  = w_cnt_b;
      w_any_n  = w_any_b;
      w_xmin_n = w_xmin_b;
      w_xmax_n = w_xmax_b;
      w_ymin_n = w_ymin_b;
      w_ymax_n = w_ymax_b;
    end
  end

  // Frame FSM, accumulators and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_thr         <= {WIDTH{1'b0}};
      r_x           <= {X_W{1'b0}};
      r_y           <= {Y_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_any         <= 1'b0;
      r_xmin        <= {X_W{1'b0}};
      r_xmax        <= {X_W{1'b0}};
      r_ymin        <= {Y_W{1'b0}};
      r_ymax        <= {Y_W{1'b0}};
      o_bin_valid   <= 1'b0;
      o_bin_sof     <= 1'b0;
      o_bin_eol     <= 1'b0;
      o_bin_eof     <= 1'b0;
      o_bin_data    <= 1'b0;
      o_stats_valid <= 1'b0;
      o_frame_abort <= 1'b0;
      o_fg_count    <= {CNT_W{1'b0}};
      o_bbox_xmin   <= {X_W{1'b0}};
      o_bbox_xmax   <= {X_W{1'b0}};
      o_bbox_ymin   <= {Y_W{1'b0}};
      o_bbox_ymax   <= {Y_W{1'b0}};
      o_bbox_empty  <= 1'b1;
    end else begin
      o_bin_valid   <= w_accept;
      o_bin_sof     <= w_accept && i_diff_sof;
      o_bin_eol     <= w_accept && i_diff_eol;
      o_bin_eof     <= w_accept && i_diff_eof;
      o_bin_data    <= w_fg;
      o_stats_valid <= w_accept && i_diff_eof;
      o_frame_abort <= w_abort;
      if (w_accept) begin
        r_thr  <= w_thr;
        r_x    <= w_x_n;
        r_y    <= w_y_n;
        r_cnt  <= w_cnt_n;
        r_any  <= w_any_n;
        r_xmin <= w_xmin_n;
        r_xmax <= w_xmax_n;
        r_ymin <= w_ymin_n;
        r_ymax <= w_ymax_n;
        if (i_diff_eof) begin
          r_state      <= ST_IDLE;
          o_fg_count   <= w_cnt_n;
          o_bbox_empty <= !w_any_n;
          o_bbox_xmin  <= w_any_n ? w_xmin_n : {X_W{1'b0}};
          o_bbox_xmax  <= w_any_n ? w_xmax_n : {X_W{1'b0}};
          o_bbox_ymin  <= w_any_n ? w_ymin_n : {Y_W{1'b0}};
          o_bbox_ymax  <= w_any_n ? w_ymax_n : {Y_W{1'b0}};
        end else begin
          r_state <= ST_ACTIVE;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

endmodule

// File: tb/tb_img_diff_binarizer.sv
// Self-checking bench for img_diff_binarizer: directed frames plus random frames
// checked cycle by cycle against a coordinate-list reference model.
module tb_img_diff_binarizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_diff_valid = 1'b0, i_diff_sof = 1'b0, i_diff_eol = 1'b0, i_diff_eof = 1'b0;
  logic [7:0]  i_diff_data = 8'd0, i_thresh = 8'd0;
  logic        o_bin_valid, o_bin_sof, o_bin_eol, o_bin_eof, o_bin_data;
  logic        o_stats_valid, o_bbox_empty, o_frame_abort;
  logic [21:0] o_fg_count;
  logic [10:0] o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax;

  img_diff_binarizer dut (
    .clk(clk), .rst_n(rst_n),
    .i_diff_valid(i_diff_valid), .i_diff_sof(i_diff_sof), .i_diff_eol(i_diff_eol),
    .i_diff_eof(i_diff_eof), .i_diff_data(i_diff_data), .i_thresh(i_thresh),
    .o_bin_valid(o_bin_valid), .o_bin_sof(o_bin_sof), .o_bin_eol(o_bin_eol),
    .o_bin_eof(o_bin_eof), .o_bin_data(o_bin_data), .o_stats_valid(o_stats_valid),
    .o_fg_count(o_fg_count), .o_bbox_xmin(o_bbox_xmin), .o_bbox_xmax(o_bbox_xmax),
    .o_bbox_ymin(o_bbox_ymin), .o_bbox_ymax(o_bbox_ymax), .o_bbox_empty(o_bbox_empty),
    .o_frame_abort(o_frame_abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: frame-open flag, latched threshold, position and the list
  // of foreground coordinates in the open frame; stats computed from the list.
  bit m_open = 1'b0;
  int m_thr = 0, m_x = 0, m_y = 0;
  int fgx[$], fgy[$];
  int ex_cnt = 0, ex_xmin = 0, ex_xmax = 0, ex_ymin = 0, ex_ymax = 0;
  bit ex_empty = 1'b1;
  logic [7:0] img [0:7][0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 1'b0; m_thr = 0; m_x = 0; m_y = 0;
    fgx.delete(); fgy.delete();
    ex_cnt = 0; ex_xmin = 0; ex_xmax = 0; ex_ymin = 0; ex_ymax = 0; ex_empty = 1'b1;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_cnt"},   32'(o_fg_count),   32'(ex_cnt));
    chk({tag, "_xmin"},  32'(o_bbox_xmin),  32'(ex_xmin));
    chk({tag, "_xmax"},  32'(o_bbox_xmax),  32'(ex_xmax));
    chk({tag, "_ymin"},  32'(o_bbox_ymin),  32'(ex_ymin));
    chk({tag, "_ymax"},  32'(o_bbox_ymax),  32'(ex_ymax));
    chk({tag, "_empty"}, 32'(o_bbox_empty), 32'(ex_empty));
  endtask

  // Drive one cycle of input, predict, clock, then compare every output.
  task automatic pix(input bit v, input bit sof, input bit eol, input bit eof,
                     input int d, input int th);
    bit acc, fg, ab, sv;
    i_diff_valid = v; i_diff_sof = sof; i_diff_eol = eol; i_diff_eof = eof;
    i_diff_data = 8'(d); i_thresh = 8'(th);
    acc = v && (sof || m_open);
    fg  = acc && (d > (sof ? th : m_thr));
    ab  = acc && sof && m_open;
    sv  = acc && eof;
    if (acc) begin
      if (sof) begin
        m_thr = th; m_x = 0; m_y = 0; fgx.delete(); fgy.delete();
      end
      if (fg) begin
        fgx.push_back(m_x); fgy.push_back(m_y);
      end
      if (eol) begin
        m_x = 0; m_y = (m_y < 2047) ? m_y + 1 : 2047;
      end else begin
        m_x = (m_x < 2047) ? m_x + 1 : 2047;
      end
      if (eof) begin
        ex_cnt = fgx.size();
        ex_empty = (ex_cnt == 0);
        ex_xmin = 0; ex_xmax = 0; ex_ymin = 0; ex_ymax = 0;
        if (ex_cnt > 0) begin
          ex_xmin = fgx.min()[0]; ex_xmax = fgx.max()[0];
          ex_ymin = fgy.min()[0]; ex_ymax = fgy.max()[0];
        end
        m_open = 1'b0;
      end else begin
        m_open = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("bin_valid",   32'(o_bin_valid),   32'(acc));
    chk("bin_data",    32'(o_bin_data),    32'(fg));
    chk("bin_sof",     32'(o_bin_sof),     32'(acc && sof));
    chk("bin_eol",     32'(o_bin_eol),     32'(acc && eol));
    chk("bin_eof",     32'(o_bin_eof),     32'(sv));
    chk("stats_valid", 32'(o_stats_valid), 32'(sv));
    chk("frame_abort", 32'(o_frame_abort), 32'(ab));
    check_stats("stats");
  endtask

  // Send nrows rows of a w x h frame from img; eof only when all rows are sent.
  // Threshold input switches from t0 to t1 halfway through the frame.
  task automatic frame(input int w, input int h, input int t0, input int t1,
                       input int nrows, input bit gaps);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps && ($urandom_range(0, 3) == 0))
          pix(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 255), t0);
        pix(1'b1, (r == 0) && (c == 0), c == w - 1, (r == h - 1) && (c == w - 1),
            int'(img[r][c]), ((r * w + c) >= (w * h) / 2) ? t1 : t0);
      end
    end
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = 8'(v);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin_valid",   32'(o_bin_valid),   32'd0);
    chk("rst_stats_valid", 32'(o_stats_valid), 32'd0);
    chk("rst_abort",       32'(o_frame_abort), 32'd0);
    check_stats("rst");
    rst_n = 1'b1;

    // Directed: two foreground pixels, one exactly at threshold-plus-one.
    fill(10); img[0][1] = 8'd11; img[2][3] = 8'd200;
    frame(4, 3, 10, 10, 3, 1'b0);
    chk("t1_cnt", 32'(o_fg_count), 32'd2);
    chk("t1_xmin", 32'(o_bbox_xmin), 32'd1);
    chk("t1_ymin", 32'(o_bbox_ymin), 32'd0);
    chk("t1_xmax", 32'(o_bbox_xmax), 32'd3);
    chk("t1_ymax", 32'(o_bbox_ymax), 32'd2);
    chk("t1_empty", 32'(o_bbox_empty), 32'd0);

    // Directed: nothing above threshold.
    fill(10);
    frame(4, 3, 10, 10, 3, 1'b0);
    chk("t2_cnt", 32'(o_fg_count), 32'd0);
    chk("t2_empty", 32'(o_bbox_empty), 32'd1);
    chk("t2_xmax", 32'(o_bbox_xmax), 32'd0);

    // Threshold changes mid-frame: only the next sof picks it up.
    frame(4, 3, 10, 0, 3, 1'b0);
    chk("t3_cnt", 32'(o_fg_count), 32'd0);
    frame(4, 3, 0, 0, 3, 1'b0);
    chk("t3b_cnt", 32'(o_fg_count), 32'd12);

    // Early sof at row 1 truncates the open frame.
    fill(50);
    frame(4, 3, 10, 10, 1, 1'b0);
    fill(10); img[1][2] = 8'd99;
    frame(4, 3, 10, 10, 3, 1'b0);
    chk("t4_cnt", 32'(o_fg_count), 32'd1);
    chk("t4_xmin", 32'(o_bbox_xmin), 32'd2);

    // One-pixel frame followed immediately by another frame.
    pix(1'b1, 1'b1, 1'b1, 1'b1, 255, 0);
    chk("t5_cnt", 32'(o_fg_count), 32'd1);
    chk("t5_empty", 32'(o_bbox_empty), 32'd0);
    fill(10); img[0][0] = 8'd20;
    frame(2, 2, 10, 10, 2, 1'b0);

    // Random frames with gaps, idle drops and occasional truncation.
    for (int f = 0; f < 30; f++) begin
      int w, h, t, nr;
      w = $urandom_range(1, 8); h = $urandom_range(1, 8);
      t = $urandom_range(0, 255); nr = ($urandom_range(0, 4) == 0) ? $urandom_range(1, h) : h;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          img[r][c] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(t);
      if (!m_open && ($urandom_range(0, 1) == 1))
        pix(1'b1, 1'b0, 1'($urandom), 1'($urandom), $urandom_range(0, 255), t);
      frame(w, h, t, $urandom_range(0, 255), nr, 1'b1);
    end

    // Reset mid-frame: outputs clear at once, sof-less pixels are then dropped.
    fill(200);
    frame(4, 3, 10, 10, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_bin_valid", 32'(o_bin_valid), 32'd0);
    chk("arst_bin_data", 32'(o_bin_data), 32'd0);
    check_stats("arst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_diff_valid = 1'b0;
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b0, i == 3, i == 3, 255, 0);
    chk("post_rst_stats", 32'(o_stats_valid), 32'd0);
    frame(4, 3, 10, 10, 3, 1'b0);
    chk("post_rst_cnt", 32'(o_fg_count), 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
